// File: rtl/sim_run_monitor_if.sv
// Observation bundle between the processor under test and sim_run_monitor.
// master drives the observed streams, slave is the monitor that reports the verdict.
interface sim_run_monitor_if #(
    parameter int NUM_HARTS = 1,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 32
);
    localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic [NUM_HARTS-1:0][ADDR_W-1:0] pc_i;
    logic [NUM_HARTS-1:0]             pc_valid_i;
    logic                             mem_en_i;
    logic                             done_i;
    logic                             done_o;
    logic                             pass_o;
    logic [3:0]                       fail_code_o;
    logic [HART_W-1:0]                fail_hart_o;
    logic [CNT_W-1:0]                 cycle_count_o;
    logic [NUM_HARTS-1:0][CNT_W-1:0]  instr_count_o;

    modport master (
        output pc_i, pc_valid_i, mem_en_i, done_i,
        input  done_o, pass_o, fail_code_o, fail_hart_o, cycle_count_o, instr_count_o
    );

    modport slave (
        input  pc_i, pc_valid_i, mem_en_i, done_i,
        output done_o, pass_o, fail_code_o, fail_hart_o, cycle_count_o, instr_count_o
    );
endinterface

// File: rtl/sim_run_monitor.sv
// Run supervisor for N PC streams: bounded run window, alignment and stall checks,
// retired-instruction counts and a registered pass/fail verdict. Observes only.
module sim_run_monitor #(
    parameter int NUM_HARTS    = 1,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 32,
    parameter int RUN_CYCLES   = 5000,
    parameter int MIN_CYCLES   = 200,
    parameter int STALL_LIMIT  = 64,
    parameter int ALIGN_MODE   = 0,
    parameter int ABORT_ON_ERR = 1
) (
    input logic              clk,
    input logic              reset,
    sim_run_monitor_if.slave bus
);
    localparam int               HART_W  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t                          state;
    logic [CNT_W-1:0]                cycle_count;
    logic [CNT_W-1:0]                cyc_nxt;
    logic [3:0]                      fail_code;
    logic [3:0]                      final_code;
    logic [HART_W-1:0]               fail_hart;
    logic [HART_W-1:0]               first_hart;
    logic                            mem_seen;
    logic                            done_q;
    logic                            pass_q;
    logic                            run;
    logic                            err_any;
    logic                            exit_run;
    logic [NUM_HARTS-1:0]            misalign;
    logic [NUM_HARTS-1:0]            stall;
    logic [NUM_HARTS-1:0]            err_vec;
    logic [NUM_HARTS-1:0][CNT_W-1:0] instr_count;

    assign run = (state == RUN);

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        sim_run_monitor_hart #(
            .ADDR_W     (ADDR_W),
            .CNT_W      (CNT_W),
            .STALL_LIMIT(STALL_LIMIT),
            .ALIGN_MODE (ALIGN_MODE)
        ) u_hart (
            .clk        (clk),
            .reset      (reset),
            .run        (run),
            .pc         (bus.pc_i[h]),
            .pc_valid   (bus.pc_valid_i[h]),
            .misalign   (misalign[h]),
            .stall      (stall[h]),
            .instr_count(instr_count[h])
        );
    end

    assign err_vec    = misalign | stall;
    assign err_any    = |err_vec;
    assign cyc_nxt    = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
    // Window expiry is judged on the incremented value so the exiting cycle is counted.
    assign exit_run   = bus.done_i || (cyc_nxt >= RUN_LIM) || ((ABORT_ON_ERR != 0) && err_any);
    assign final_code = {~mem_seen, (cycle_count < MIN_LIM), fail_code[1:0]};

    always_comb begin
        first_hart = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (err_vec[h]) first_hart = HART_W'(h);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cycle_count <= '0;
            fail_code   <= '0;
            fail_hart   <= '0;
            mem_seen    <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    cycle_count <= cyc_nxt;
                    mem_seen    <= mem_seen | bus.mem_en_i;
                    fail_code   <= fail_code | {2'b00, |stall, |misalign};
                    // Only the first erroring cycle names the hart.
                    if (err_any && (fail_code[1:0] == 2'b00)) fail_hart <= first_hart;
                    if (exit_run) state <= CHECK;
                end
                CHECK: begin
                    fail_code <= final_code;
                    pass_q    <= (final_code == 4'b0000);
                    done_q    <= 1'b1;
                    state     <= DONE;
                end
                default: state <= DONE;
            endcase
        end
    end

    assign bus.done_o        = done_q;
    assign bus.pass_o        = pass_q;
    assign bus.fail_code_o   = fail_code;
    assign bus.fail_hart_o   = fail_hart;
    assign bus.cycle_count_o = cycle_count;
    assign bus.instr_count_o = instr_count;
endmodule

// Per-hart checker: retired-instruction counter, alignment check and stall watchdog.
module sim_run_monitor_hart #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 64,
    parameter int ALIGN_MODE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              misalign,
    output logic              stall,
    output logic [CNT_W-1:0]  instr_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);

    logic [ADDR_W-1:0] last_pc;
    logic              have_last;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  stall_nxt;
    logic              sample;
    logic              same_pc;

    assign sample  = run && pc_valid;
    assign same_pc = have_last && (pc == last_pc);

    always_comb begin
        stall_nxt = stall_cnt;
        if (sample) begin
            if (!same_pc)                 stall_nxt = '0;
            else if (stall_cnt != CNT_MAX) stall_nxt = stall_cnt + 1'b1;
        end
    end

    assign misalign = sample && ((ALIGN_MODE != 0) ? pc[0] : (pc[1:0] != 2'b00));
    assign stall    = (STALL_LIMIT != 0) && sample && same_pc && (stall_nxt >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc     <= '0;
            have_last   <= 1'b0;
            stall_cnt   <= '0;
            instr_count <= '0;
        end else if (sample) begin
            last_pc   <= pc;
            have_last <= 1'b1;
            stall_cnt <= stall_nxt;
            if (instr_count != CNT_MAX) instr_count <= instr_count + 1'b1;
        end
    end
endmodule

// File: doc/sim_run_monitor.md
Name: sim_run_monitor

Overview:
Synthesizable run-supervision block for processor-level benches and FPGA bring-up. Generalises the cycle-count / PC-alignment / memory-enable / timeout checks to N harts. Adds selectable alignment mode, per-hart stall watchdog, retired-instruction counters, early termination and a structured pass/fail verdict. Sits beside riscv_processor and observes its PC streams and external memory enable; it never drives the core.

Parameters:
NUM_HARTS, 1, number of observed PC streams
ADDR_W, 32, PC width
CNT_W, 32, width of cycle and instruction counters
RUN_CYCLES, 5000, maximum run window in cycles; the run ends after this many RUN cycles
MIN_CYCLES, 200, minimum cycles required for a pass
STALL_LIMIT, 64, consecutive valid cycles with an unchanged PC that flag a stall; 0 disables the watchdog
ALIGN_MODE, 0, 0 = 4-byte PC alignment, 1 = 2-byte alignment (compressed ISA)
ABORT_ON_ERR, 1, 1 = a stall or misalign error ends the run immediately

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pc_i  in  NUM_HARTS*ADDR_W  per-hart PC; hart h occupies bits [h*ADDR_W +: ADDR_W]
pc_valid_i  in  NUM_HARTS  per-hart PC valid (one retired instruction)
mem_en_i  in  1  processor external memory enable
done_i  in  1  end-of-test request from the bench or software
done_o  out  1  verdict available; held until reset
pass_o  out  1  done_o && fail_code_o==0
fail_code_o  out  4  bit0 misalign, bit1 stall, bit2 min-cycles not met, bit3 mem_en never seen
fail_hart_o  out  HART_W  hart that raised the first error; HART_W = max(1,$clog2(NUM_HARTS))
cycle_count_o  out  CNT_W  RUN cycles elapsed
instr_count_o  out  NUM_HARTS*CNT_W  per-hart count of cycles with pc_valid high

Behaviour:
- Reset (synchronous, active-high): all outputs 0, all counters and sticky flags 0, state IDLE. Reset asserted in any state, including mid-run or DONE, returns the block to IDLE on that edge.
- State machine:
  - IDLE -> RUN on the first clock with reset low.
  - RUN -> CHECK on any of: done_i=1; cycle_count reaching RUN_CYCLES on this edge; a new error when ABORT_ON_ERR=1.
  - CHECK -> DONE after exactly 1 cycle.
  - DONE is terminal.
- Counting in RUN:
  - cycle_count increments every RUN clock, including the exiting cycle.
  - instr_count[h] increments on pc_valid_i[h].
  - All counters saturate at all-ones. Counters freeze outside RUN.
- Alignment check (every RUN cycle with pc_valid_i[h]=1):
  - Misaligned if pc[1:0]!=0 (ALIGN_MODE=0) or pc[0]!=0 (ALIGN_MODE=1).
  - Sets sticky fail_code bit0.
- Stall watchdog, per hart:
  - The first valid sample loads last_pc with no compare.
  - Each later valid sample with pc==last_pc increments stall_cnt; a different PC clears stall_cnt and reloads last_pc.
  - Invalid cycles hold stall_cnt.
  - When stall_cnt reaches STALL_LIMIT, sticky fail_code bit1 is set.
- mem_en tracking: a sticky mem_seen flag is set on any RUN cycle with mem_en_i=1.
- fail_hart_o:
  - Captures the lowest-index erroring hart on the first cycle any error occurs.
  - Later errors do not update it.
  - Stays 0 if no per-hart error occurs.
- CHECK cycle:
  - Sets bit2 if cycle_count < MIN_CYCLES.
  - Sets bit3 if mem_seen=0.
- DONE: done_o=1 and pass_o are registered and valid from the first DONE cycle. All outputs are held until reset.
- Simultaneous events: an error and done_i, or an error and window expiry, in the same cycle both record the error; a single exit occurs. done_i is ignored outside RUN.
- Latency: exit condition at edge N; CHECK during cycle N+1; done_o=1 from edge N+2.

Test Plan:
- NUM_HARTS=1, PC stepping +4 from 0, mem_en pulsed at cycle 10, no done_i -> cycle_count=5000, done_o after 5002 cycles, pass_o=1, fail_code=0, instr_count=5000.
- done_i at cycle 100 with the stream above -> cycle_count=100, fail_code=4'b0100, pass_o=0.
- Hart 1 of 2 emits PC 0x102, ALIGN_MODE=0, ABORT_ON_ERR=1 -> fail_code bit0, fail_hart_o=1, early done. Same PC with ALIGN_MODE=1 -> no error.
- PC held at 0x40 with valid high, STALL_LIMIT=64 -> bit1 set on the 64th repeat sample. With STALL_LIMIT=0 -> no stall error, run completes.
- mem_en_i never asserted over the full window -> fail_code=4'b1000, pass_o=0.
- reset pulsed at cycle 300 mid-run -> all outputs 0 next edge; run restarts and cycle_count counts from 0 again.
